fifo_p2s_serializer: RTL and testbench
======================================

# fifo_p2s_serializer

Parallel-to-serial stage directly downstream of the parameterised FIFO. It pops one FIFO_WIDTH-bit word at a time and shifts it out one bit per accepted beat on a valid/ready serial interface, flagging the final bit of each word. It is the FIFO's only reader and never pops an empty FIFO.

## Interface
- FIFO_WIDTH, 11: word width. Must equal the FIFO's FIFO_WIDTH. Minimum 2.
- MSB_FIRST, 1: 1 shifts bit FIFO_WIDTH-1 first; 0 shifts bit 0 first.

- clk, input, 1: single clock; all logic is rising-edge.
- rstn, input, 1: asynchronous, active-low reset.
- empty, input, 1: FIFO empty flag.
- pop, output, 1: FIFO read strobe.
- pop_data, input, FIFO_WIDTH: FIFO read data, valid the cycle after pop.
- ser_valid, output, 1: ser_data holds a valid bit.
- ser_ready, input, 1: sink accepts the bit when high together with ser_valid.
- ser_data, output, 1: current serial bit; 0 when ser_valid=0.
- ser_last, output, 1: current bit is the last bit of its word; 0 when ser_valid=0.
- busy, output, 1: state is not IDLE.

## Operation
- Registers:
  - shift register shreg, FIFO_WIDTH bits.
  - bit counter cnt, $clog2(FIFO_WIDTH) bits.
  - FSM with states IDLE, WAIT, SHIFT.
- pop is combinational and is 1 only in these cases:
  - state=IDLE and empty=0.
  - state=SHIFT, cnt=FIFO_WIDTH-1, ser_ready=1 and empty=0.
- IDLE:
  - ser_valid=0.
  - If empty=0: assert pop and go to WAIT. Otherwise stay in IDLE.
- WAIT:
  - ser_valid=0.
  - Load shreg<=pop_data and cnt<=0, then go to SHIFT unconditionally.
- SHIFT:
  - ser_valid=1.
  - ser_data = shreg[FIFO_WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - ser_last = (cnt==FIFO_WIDTH-1).
  - On handshake (ser_valid & ser_ready) with ser_last=0: shift shreg one position toward the output end, zero-fill, cnt<=cnt+1.
  - On handshake with ser_last=1: go to WAIT if empty=0 (pop asserted the same cycle), else go to IDLE.
  - With ser_ready=0: ser_data and ser_last hold their values; nothing changes.
- cnt never exceeds FIFO_WIDTH-1. It is reset to 0 on every load, so it does not wrap.
- A word is never dropped or duplicated. Exactly one pop per word, and every popped word produces exactly FIFO_WIDTH accepted bits.
- Reset (rstn=0), at any time including mid-word:
  - Immediately forces state=IDLE, shreg=0, cnt=0.
  - Outputs become pop=0, ser_valid=0, ser_data=0, ser_last=0, busy=0.
  - A partially shifted word is discarded.
  - A pop issued in the cycle reset asserts is lost; this is accepted because the FIFO shares the same reset.

## Timing
- Start-up latency: empty falls in IDLE during cycle N, pop=1 in cycle N, state WAIT in N+1, first bit valid in N+2.
- Word cost: FIFO_WIDTH accepted beats plus one WAIT bubble. Steady-state throughput is FIFO_WIDTH bits per FIFO_WIDTH+1 cycles when ser_ready stays high.
- Between words, ser_valid drops for exactly one cycle (WAIT) when the FIFO is non-empty at the last-bit handshake. It drops for 2 or more cycles when the path goes through IDLE.
- Back-pressure: ser_ready may drop at any bit, including the last. While stalled, pop stays 0 and the output holds.
- Interface constraint: the FIFO must present pop_data one cycle after pop, registered, and must not change it until the next pop.

## Test plan
- Single word, MSB_FIRST=1: push 11'h5A3, ser_ready=1. Expect one pop, then ser_data = 1,0,1,1,0,1,0,0,0,1,1 on 11 consecutive cycles, ser_last only on the 11th, then IDLE with busy=0.
- Single word, MSB_FIRST=0: push 11'h5A3. Expect ser_data = 1,1,0,0,0,1,0,1,1,0,1.
- Back-to-back: push 3 words, ser_ready=1. Expect 3 pops, each word's 11 bits in order, exactly one ser_valid=0 cycle between words, total 35 cycles from the first pop to the final ser_last.
- Back-pressure: random ser_ready, including a stall on ser_last. Expect the bit stream identical to the unstalled case, ser_data/ser_last stable while stalled, and no pop during a stall.
- Empty guard: FIFO empty for 20 cycles, then one word. Expect pop=0 throughout the empty period and no pop after the last bit while the FIFO is empty.
- Reset mid-word: assert rstn=0 after 4 bits of 11'h7FF. Expect all outputs 0 immediately. After release with a new word 11'h001 pushed, expect a clean 11-bit output of 0,0,0,0,0,0,0,0,0,0,1 (MSB_FIRST=1).

Source files
------------

// File: rtl/fifo_p2s_serializer_if.sv
// Handshake bundle between the serializer, its upstream FIFO and the serial sink.
// master is the serializer side; slave is the FIFO/sink side.
interface fifo_p2s_serializer_if #(
    parameter int unsigned FIFO_WIDTH = 11
) ();
    logic                  empty;
    logic                  pop;
    logic [FIFO_WIDTH-1:0] pop_data;
    logic                  ser_valid;
    logic                  ser_ready;
    logic                  ser_data;
    logic                  ser_last;

    modport master (
        input  empty, pop_data, ser_ready,
        output pop, ser_valid, ser_data, ser_last
    );

    modport slave (
        output empty, pop_data, ser_ready,
        input  pop, ser_valid, ser_data, ser_last
    );
endinterface

// File: rtl/fifo_p2s_serializer.sv
// Pops one word at a time from the upstream FIFO and shifts it out bit-serially
// over a valid/ready link, marking the final bit of each word.
module fifo_p2s_serializer #(
    parameter int unsigned FIFO_WIDTH = 11,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    fifo_p2s_serializer_if.master bus,
    output logic                  busy
);
    localparam int unsigned      CNT_W    = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIFO_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [FIFO_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;
    logic                  last_bit;
    logic                  handshake;

    assign last_bit  = (cnt == CNT_LAST);
    assign handshake = (state == SHIFT) && bus.ser_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // WAIT always lasts one cycle: the FIFO presents pop_data one cycle after pop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.empty) state_nxt = WAIT;
            WAIT:    state_nxt = SHIFT;
            SHIFT:   if (handshake && last_bit) state_nxt = bus.empty ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.pop       = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        bus.ser_last  = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: bus.pop = !bus.empty;
            SHIFT: begin
                bus.ser_valid = 1'b1;
                bus.ser_data  = MSB_FIRST ? shreg[FIFO_WIDTH-1] : shreg[0];
                bus.ser_last  = last_bit;
                bus.pop       = handshake && last_bit && !bus.empty;
            end
            default: ;
        endcase
    end

    // Shift toward the output end with zero fill; the last bit is never shifted past.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (state == WAIT) begin
            shreg <= bus.pop_data;
            cnt   <= '0;
        end else if (handshake && !last_bit) begin
            if (MSB_FIRST) shreg <= {shreg[FIFO_WIDTH-2:0], 1'b0};
            else           shreg <= {1'b0, shreg[FIFO_WIDTH-1:1]};
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fifo_p2s_serializer.sv
// Directed bench: an MSB-first and an LSB-first serializer share one FIFO model,
// one ready line and one reset; each task checks its scenario inline.
module tb_fifo_p2s_serializer;
    localparam int unsigned W = 11;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic busy_a;
    logic busy_b;

    logic         fifo_empty;
    logic [W-1:0] fifo_dout;
    logic         push_req;
    logic [W-1:0] push_word;
    logic         ready;
    logic [W-1:0] fq[$];
    int           underflow = 0;

    int total = 0;
    int bad   = 0;

    fifo_p2s_serializer_if #(.FIFO_WIDTH(W)) ifa ();
    fifo_p2s_serializer_if #(.FIFO_WIDTH(W)) ifb ();

    assign ifa.empty     = fifo_empty;
    assign ifa.pop_data  = fifo_dout;
    assign ifa.ser_ready = ready;
    assign ifb.empty     = fifo_empty;
    assign ifb.pop_data  = fifo_dout;
    assign ifb.ser_ready = ready;

    fifo_p2s_serializer #(.FIFO_WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rstn(rstn), .bus(ifa), .busy(busy_a)
    );
    fifo_p2s_serializer #(.FIFO_WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .bus(ifb), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, registered empty, popped by dut_a.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fq.delete();
            fifo_dout  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (ifa.pop) begin
                if (fq.size() == 0) underflow <= underflow + 1;
                else                fifo_dout <= fq.pop_front();
            end
            if (push_req) fq.push_back(push_word);
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ifa.pop !== 1'b0 || ifa.ser_valid !== 1'b0 || ifa.ser_data !== 1'b0 ||
            ifa.ser_last !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: pop=%b valid=%b data=%b last=%b busy=%b, required all 0",
                     ifa.pop, ifa.ser_valid, ifa.ser_data, ifa.ser_last, busy_a);
        end
        rstn = 1'b1;
        repeat (3) step();
        total++;
        if (busy_a !== 1'b0 || ifa.ser_valid !== 1'b0 || ifa.pop !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b valid=%b pop=%b, required 0 0 0",
                     busy_a, ifa.ser_valid, ifa.pop);
        end
    endtask

    task automatic test_msb_single();
        logic [0:10] exp;
        int k = 0, pops = 0, pop_c = -1, first = -1, lastc = -1;
        exp = 11'b10110100011;
        ready = 1'b1;
        push_req = 1'b1;
        push_word = 11'h5A3;
        for (int c = 0; c < 40 && k < 11; c++) begin
            step();
            push_req = 1'b0;
            if (ifa.pop) begin
                pops++;
                if (pop_c < 0) pop_c = c;
            end
            if (ifa.ser_valid) begin
                if (first < 0) first = c;
                total++;
                if (ifa.ser_data !== exp[k] || ifa.ser_last !== (k == 10)) begin
                    bad++;
                    $display("FAIL msb_bit%0d: data=%b last=%b, required data=%b last=%b",
                             k, ifa.ser_data, ifa.ser_last, exp[k], (k == 10));
                end
                if (ifa.ser_last) lastc = c;
                k++;
            end
        end
        total++;
        if (k != 11 || lastc - first != 10 || first - pop_c != 2) begin
            bad++;
            $display("FAIL msb_timing: bits=%0d span=%0d latency=%0d, required 11 10 2",
                     k, lastc - first, first - pop_c);
        end
        step();
        total++;
        if (busy_a !== 1'b0 || ifa.ser_valid !== 1'b0 || pops != 1) begin
            bad++;
            $display("FAIL msb_end: busy=%b valid=%b pops=%0d, required 0 0 1",
                     busy_a, ifa.ser_valid, pops);
        end
    endtask

    task automatic test_lsb_single();
        logic [0:10] exp;
        int k = 0, pops = 0;
        exp = 11'b11000101101;
        ready = 1'b1;
        push_req = 1'b1;
        push_word = 11'h5A3;
        for (int c = 0; c < 40 && k < 11; c++) begin
            step();
            push_req = 1'b0;
            if (ifb.pop) pops++;
            if (ifb.ser_valid) begin
                total++;
                if (ifb.ser_data !== exp[k] || ifb.ser_last !== (k == 10)) begin
                    bad++;
                    $display("FAIL lsb_bit%0d: data=%b last=%b, required data=%b last=%b",
                             k, ifb.ser_data, ifb.ser_last, exp[k], (k == 10));
                end
                k++;
            end
        end
        step();
        total++;
        if (k != 11 || pops != 1 || busy_b !== 1'b0) begin
            bad++;
            $display("FAIL lsb_end: bits=%0d pops=%0d busy=%b, required 11 1 0", k, pops, busy_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        logic [W-1:0] w;
        int k = 0, pops = 0, pop_c = -1, lastc = -1, bubbles = 0;
        bit started = 0;
        words = '{11'h5A3, 11'h0F0, 11'h7A5};
        ready = 1'b1;
        push_req = 1'b1;
        push_word = words[0];
        for (int c = 0; c < 100 && k < 33; c++) begin
            step();
            if (c + 1 < 3) push_word = words[c+1];
            else           push_req  = 1'b0;
            if (ifa.pop) begin
                pops++;
                if (pop_c < 0) pop_c = c;
            end
            if (!ifa.ser_valid && started) bubbles++;
            if (ifa.ser_valid) begin
                started = 1;
                w = words[k/11];
                total++;
                if (ifa.ser_data !== w[10-(k%11)] || ifa.ser_last !== ((k % 11) == 10)) begin
                    bad++;
                    $display("FAIL b2b_bit%0d: data=%b last=%b, required data=%b last=%b",
                             k, ifa.ser_data, ifa.ser_last, w[10-(k%11)], ((k % 11) == 10));
                end
                if (ifa.ser_last) lastc = c;
                k++;
            end
        end
        // 35 cycles lie strictly between the first pop and the final ser_last.
        total++;
        if (k != 33 || pops != 3 || bubbles != 2 || lastc - pop_c - 1 != 35) begin
            bad++;
            $display("FAIL b2b_shape: bits=%0d pops=%0d bubbles=%0d gap=%0d, required 33 3 2 35",
                     k, pops, bubbles, lastc - pop_c - 1);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] words [3];
        logic [W-1:0] w;
        int k = 0, pops = 0;
        bit prev_stall = 0, last_stalled = 0;
        logic pdata = 1'b0, plast = 1'b0;
        words = '{11'h5A3, 11'h3C9, 11'h64E};
        push_req = 1'b1;
        push_word = words[0];
        for (int c = 0; c < 400 && k < 33; c++) begin
            step();
            if (c + 1 < 3) push_word = words[c+1];
            else           push_req  = 1'b0;
            if (prev_stall) begin
                total++;
                if (ifa.ser_valid !== 1'b1 || ifa.ser_data !== pdata || ifa.ser_last !== plast) begin
                    bad++;
                    $display("FAIL bp_hold: valid=%b data=%b last=%b, required 1 %b %b",
                             ifa.ser_valid, ifa.ser_data, ifa.ser_last, pdata, plast);
                end
            end
            if (ifa.ser_valid && ifa.ser_last && !last_stalled) begin
                ready = 1'b0;
                last_stalled = 1;
            end else begin
                ready = ($urandom_range(0, 2) != 0);
            end
            #1;
            if (ifa.pop) pops++;
            prev_stall = ifa.ser_valid && !ready;
            pdata = ifa.ser_data;
            plast = ifa.ser_last;
            if (prev_stall) begin
                total++;
                if (ifa.pop !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_pop_in_stall: pop=%b, required 0", ifa.pop);
                end
            end
            if (ifa.ser_valid && ready) begin
                w = words[k/11];
                total++;
                if (ifa.ser_data !== w[10-(k%11)] || ifa.ser_last !== ((k % 11) == 10)) begin
                    bad++;
                    $display("FAIL bp_bit%0d: data=%b last=%b, required data=%b last=%b",
                             k, ifa.ser_data, ifa.ser_last, w[10-(k%11)], ((k % 11) == 10));
                end
                if (ifa.ser_last) last_stalled = 0;
                k++;
            end
        end
        total++;
        if (k != 33 || pops != 3) begin
            bad++;
            $display("FAIL bp_count: bits=%0d pops=%0d, required 33 3", k, pops);
        end
        ready = 1'b1;
        step();
    endtask

    task automatic test_empty_guard();
        logic [W-1:0] w;
        int k = 0, pops = 0;
        w = 11'h2B4;
        ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            total++;
            if (ifa.pop !== 1'b0 || ifa.ser_valid !== 1'b0) begin
                bad++;
                $display("FAIL empty_idle_c%0d: pop=%b valid=%b, required 0 0",
                         c, ifa.pop, ifa.ser_valid);
            end
        end
        push_req = 1'b1;
        push_word = w;
        for (int c = 0; c < 40 && k < 11; c++) begin
            step();
            push_req = 1'b0;
            if (ifa.pop) pops++;
            if (ifa.ser_valid) begin
                total++;
                if (ifa.ser_data !== w[10-k]) begin
                    bad++;
                    $display("FAIL empty_word_bit%0d: data=%b, required %b", k, ifa.ser_data, w[10-k]);
                end
                k++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            step();
            if (ifa.pop) pops++;
        end
        total++;
        if (k != 11 || pops != 1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL empty_after: bits=%0d pops=%0d busy=%b, required 11 1 0", k, pops, busy_a);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [0:10] exp;
        int k = 0, pops = 0;
        exp = 11'b00000000001;
        ready = 1'b1;
        push_req = 1'b1;
        push_word = 11'h7FF;
        for (int c = 0; c < 40 && k < 4; c++) begin
            step();
            push_req = 1'b0;
            if (ifa.ser_valid) k++;
        end
        step();
        rstn = 1'b0;
        #1;
        total++;
        if (ifa.pop !== 1'b0 || ifa.ser_valid !== 1'b0 || ifa.ser_data !== 1'b0 ||
            ifa.ser_last !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            bad++;
            $display("FAIL midword_reset: pop=%b valid=%b data=%b last=%b busy=%b/%b, required all 0",
                     ifa.pop, ifa.ser_valid, ifa.ser_data, ifa.ser_last, busy_a, busy_b);
        end
        repeat (2) step();
        rstn = 1'b1;
        step();
        k = 0;
        push_req = 1'b1;
        push_word = 11'h001;
        for (int c = 0; c < 40 && k < 11; c++) begin
            step();
            push_req = 1'b0;
            if (ifa.pop) pops++;
            if (ifa.ser_valid) begin
                total++;
                if (ifa.ser_data !== exp[k] || ifa.ser_last !== (k == 10)) begin
                    bad++;
                    $display("FAIL post_reset_bit%0d: data=%b last=%b, required data=%b last=%b",
                             k, ifa.ser_data, ifa.ser_last, exp[k], (k == 10));
                end
                k++;
            end
        end
        step();
        total++;
        if (k != 11 || pops != 1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_end: bits=%0d pops=%0d busy=%b, required 11 1 0", k, pops, busy_a);
        end
    endtask

    task automatic test_no_underflow();
        total++;
        if (underflow != 0) begin
            bad++;
            $display("FAIL underflow: pops of empty FIFO=%0d, required 0", underflow);
        end
    endtask

    initial begin
        push_req  = 1'b0;
        push_word = '0;
        ready     = 1'b0;
        #1 rstn = 1'b0;
        test_reset();
        test_msb_single();
        test_lsb_single();
        test_back_to_back();
        test_backpressure();
        test_empty_guard();
        test_reset_mid_word();
        test_no_underflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
